// File: rtl/mdu_pkg.sv
// Shared types and sizing for the RV32M multiply/divide sequencer.
package mdu_pkg;

  localparam int MDU_XLEN = 32;
  // Counter must reach XLEN, so one bit beyond log2.
  localparam int CNT_W = $clog2(MDU_XLEN) + 1;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/mdu_iter_core.sv
// Per-cycle datapath: right-shifting shift-add multiply or restoring divide on
// unsigned magnitudes. hi/lo hold product high/low or remainder/quotient.
module mdu_iter_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] a_mag,
  input  logic [XLEN-1:0] b_mag,
  output logic [XLEN-1:0] hi_nxt,
  output logic [XLEN-1:0] lo_nxt
);

  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] opb;
  logic [XLEN-1:0] quo;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   trial;

  always_comb begin
    sum    = '0;
    trial  = '0;
    hi_nxt = acc;
    lo_nxt = quo;
    if (is_div) begin
      // acc < divisor always holds, so bit XLEN of trial flags a borrow.
      trial = {acc, quo[XLEN-1]} - {1'b0, opb};
      if (!trial[XLEN]) begin
        hi_nxt = trial[XLEN-1:0];
        lo_nxt = {quo[XLEN-2:0], 1'b1};
      end else begin
        hi_nxt = {acc[XLEN-2:0], quo[XLEN-1]};
        lo_nxt = {quo[XLEN-2:0], 1'b0};
      end
    end else begin
      sum    = {1'b0, acc} + (quo[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
      hi_nxt = sum[XLEN:1];
      lo_nxt = {sum[0], quo[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      opb <= '0;
      quo <= '0;
    end else if (load) begin
      acc <= '0;
      opb <= b_mag;
      quo <= a_mag;
    end else if (step) begin
      acc <= hi_nxt;
      quo <= lo_nxt;
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// RV32M multiply/divide controller in Execute: stalls the front of the pipe for
// XLEN iterations (or one cycle for divide special cases) and presents a result.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            StartE_i,
  input  logic [2:0]      FunctE_i,
  input  logic [XLEN-1:0] SrcAE_i,
  input  logic [XLEN-1:0] SrcBE_i,
  input  logic            KillE_i,
  output logic            StallMDU_o,
  output logic            DoneE_o,
  output logic [XLEN-1:0] ResultE_o,
  output logic [1:0]      StateDbg_o
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_t       state;
  mdu_op_t          op_q;
  logic             neg_q;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  result_q;

  mdu_op_t          op_in;
  logic             signed_a, signed_b, sign_a, sign_b, neg_in;
  logic [XLEN-1:0]  a_mag, b_mag;
  logic             special_in;
  logic [XLEN-1:0]  special_res;
  logic [XLEN-1:0]  hi_nxt, lo_nxt;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]  fixed_res;
  logic             core_load, core_step;

  // Decode of the op currently presented by Execute (used only in IDLE).
  always_comb begin
    op_in    = mdu_op_t'(FunctE_i);
    signed_a = (op_in == OP_MUL) || (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
               (op_in == OP_DIV) || (op_in == OP_REM);
    signed_b = (op_in == OP_MUL) || (op_in == OP_MULH) ||
               (op_in == OP_DIV) || (op_in == OP_REM);
    sign_a   = signed_a & SrcAE_i[XLEN-1];
    sign_b   = signed_b & SrcBE_i[XLEN-1];
    a_mag    = sign_a ? -SrcAE_i : SrcAE_i;
    b_mag    = sign_b ? -SrcBE_i : SrcBE_i;
    neg_in   = (op_in == OP_REM) ? sign_a : (sign_a ^ sign_b);

    special_in  = 1'b0;
    special_res = '0;
    if (FunctE_i[2]) begin
      if (SrcBE_i == '0) begin
        special_in  = 1'b1;
        special_res = FunctE_i[1] ? SrcAE_i : '1;
      end else if (signed_a && SrcAE_i == INT_MIN && SrcBE_i == '1) begin
        special_in  = 1'b1;
        special_res = FunctE_i[1] ? '0 : INT_MIN;
      end
    end
  end

  always_comb begin
    prod     = {hi_nxt, lo_nxt};
    prod_fix = neg_q ? -prod : prod;
    if (!op_q[2])
      fixed_res = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    else if (op_q[1])
      fixed_res = neg_q ? -hi_nxt : hi_nxt;
    else
      fixed_res = neg_q ? -lo_nxt : lo_nxt;
  end

  assign core_load = !rst_i && !KillE_i && (state == IDLE) && StartE_i;
  assign core_step = !KillE_i && (state == RUN);

  mdu_iter_core #(.XLEN(XLEN)) u_core (
    .clk    (clk_i),
    .rst    (rst_i),
    .load   (core_load),
    .step   (core_step),
    .is_div (op_q[2]),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .hi_nxt (hi_nxt),
    .lo_nxt (lo_nxt)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      cnt      <= '0;
      result_q <= '0;
    end else if (KillE_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (StartE_i) begin
          op_q  <= op_in;
          neg_q <= neg_in;
          cnt   <= '0;
          if (special_in) begin
            result_q <= special_res;
            state    <= DONE;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(XLEN - 1)) begin
            result_q <= fixed_res;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake: StartE_i marks a valid op in Execute and stays asserted while
  // StallMDU_o holds Execute; DoneE_o (stall low) means ResultE_o is consumed at
  // the next edge. KillE_i drops the stall and the op in the same cycle.
  assign StallMDU_o = !rst_i && !KillE_i &&
                      (((state == IDLE) && StartE_i) || (state == RUN));
  assign DoneE_o    = !KillE_i && (state == DONE);
  assign ResultE_o  = result_q;
  assign StateDbg_o = state;

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Iterative multiply/divide controller for the RV32M extension, attached to the Execute stage of the 5-stage pipeline.
- Accepts an M-extension op held in Execute and runs a shift-add or restoring-divide sequence over XLEN cycles.
- Raises a stall that freezes F/D/E and bubbles M until the result is ready.
- The hazard unit ORs its stall into StallF/StallD and drives StallE/FlushM from it.

Parameters:
- XLEN, 32, operand/result width; also the iteration count.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-high reset
- StartE_i  input  1  valid M-extension instruction in Execute
- FunctE_i  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SrcAE_i  input  XLEN  forwarded rs1 value
- SrcBE_i  input  XLEN  forwarded rs2 value
- KillE_i  input  1  abort the in-flight op (trap/flush)
- StallMDU_o  output  1  hold F/D/E, insert bubble into M
- DoneE_o  output  1  result valid this cycle
- ResultE_o  output  XLEN  registered result

Behaviour:
- Reset: state IDLE, counter 0, all internal registers 0; StallMDU_o=0, DoneE_o=0, ResultE_o=0. Reset mid-operation discards the op.
- FSM states: IDLE, RUN, DONE.
- IDLE with StartE_i=1 and KillE_i=0:
  - StallMDU_o=1 combinationally in the same cycle.
  - Latch funct3 and operands.
  - Compute operand signs and magnitudes.
  - Next state: DONE if the op is a special case, otherwise RUN with counter=0.
- Special cases, resolved without iteration:
  - DIV/DIVU divisor 0: quotient all ones.
  - REM/REMU divisor 0: remainder = dividend.
  - DIV with 0x80000000 / 0xFFFFFFFF: quotient 0x80000000.
  - REM with 0x80000000 / 0xFFFFFFFF: remainder 0.
- RUN:
  - StallMDU_o=1.
  - One iteration per cycle: shift-add on 2*XLEN product for MUL*, restoring subtract for DIV*/REM*, both on unsigned magnitudes.
  - Counter increments each cycle.
  - After XLEN iterations, apply sign fix-up (negate per op rules) and register ResultE_o; next state DONE.
- Signedness:
  - MUL/MULH: both signed.
  - MULHSU: A signed, B unsigned.
  - MULHU/DIVU/REMU: unsigned.
  - Quotient sign = sign A XOR sign B.
  - Remainder sign = sign A.
- Result selection: MUL takes the low XLEN bits of the product; MULH* take the high XLEN bits.
- DONE:
  - DoneE_o=1, StallMDU_o=0, so Execute advances at the next edge. ResultE_o is stable through DONE.
  - Next state IDLE unconditionally. StartE_i is ignored in DONE because it still reflects the same instruction.
- Latency, with the start cycle as cycle 0:
  - Normal op: stall cycles 0..XLEN (XLEN+1 cycles); DoneE_o in cycle XLEN+1.
  - Special case: stall cycle 0 only; DoneE_o in cycle 1.
- Back-to-back: a new op can start the cycle after DONE, when IDLE sees the next StartE_i.
- KillE_i:
  - Has priority in every state.
  - Forces StallMDU_o=0 combinationally and next state IDLE.
  - No DoneE_o is produced; ResultE_o keeps its old value.
  - KillE_i together with StartE_i in IDLE means no start.
- ResultE_o updates only on entry to DONE.

Decomposition:
- Package mdu_pkg:
  - funct3 enum mdu_op_t with the 8 encodings.
  - State enum mdu_state_t.
  - Localparam for the counter width, $clog2(XLEN)+1.
- Sub-module mdu_iter_core: the per-cycle shift/add/subtract datapath holding the accumulator, multiplicand/divisor and quotient registers; controlled by load/step signals from the FSM.
- The FSM, special-case detection and sign fix-up remain in mdu_sequencer.

Test Plan:
- MUL 7 x 0xFFFFFFFD (-3) -> StallMDU_o high for cycles 0..32, DoneE_o at cycle 33, ResultE_o=0xFFFFFFEB.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> ResultE_o=0xFFFFFFFE at cycle 33; MULH same operands -> 0x00000000.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; each Done at cycle 33.
- DIVU 100 / 0 -> 0xFFFFFFFF; REMU 100 / 0 -> 100; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. All special cases: stall for cycle 0 only, Done at cycle 1.
- KillE_i pulsed at cycle 10 of a DIVU -> StallMDU_o=0 in cycle 10, state IDLE at cycle 11, no DoneE_o, ResultE_o unchanged. Repeat with rst_i instead of KillE_i: all outputs 0.
- Back-to-back MUL then DIVU with StartE_i held high across DONE -> exactly one DoneE_o per op, second op starts the cycle after the first DONE, both results correct.
